// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - register map constants, data width and shared helpers for io_input_unit
package io_pkg;

  localparam int IO_DATA_W = 32;

  localparam logic [1:0] IO_ADDR_SW   = 2'd0;
  localparam logic [1:0] IO_ADDR_BTN  = 2'd1;
  localparam logic [1:0] IO_ADDR_EVT  = 2'd2;
  localparam logic [1:0] IO_ADDR_MASK = 2'd3;

  typedef logic [IO_DATA_W-1:0] io_data_t;

  // Counter must be able to hold the value DB_CYCLES.
  function automatic int db_cnt_w(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button 2-flop synchronizer, debounce counter and rising-edge pulse
module btn_debounce
  import io_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise,
  output logic pulse
);

  localparam int CW = db_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= button;
      sync2   <= sync1;
      level_q <= level;
      pulse   <= rise;
      // Accept only after DB_CYCLES consecutive disagreeing samples.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/io_input_unit.sv
// rtl/io_input_unit.sv - synchronized switches, debounced buttons, event flags and CPU register port
// Optional feature macro IO_IRQ_EN adds the irq mask register at addr 3 and the irq output.
module io_input_unit
  import io_pkg::*;
#(
  parameter int NUM_BTN   = 1,
  parameter int SW_WIDTH  = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic                 clk_hw,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  Switches,
  input  logic [NUM_BTN-1:0]   Button,
  input  logic [1:0]           addr,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [IO_DATA_W-1:0] wdata,
  output logic [IO_DATA_W-1:0] rdata,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_pulse
`ifdef IO_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic [SW_WIDTH-1:0] sw_sync1;
  logic [SW_WIDTH-1:0] sw_sync2;
  logic [NUM_BTN-1:0]  btn_rise;
  logic [NUM_BTN-1:0]  evt;
  logic [NUM_BTN-1:0]  evt_clr;
  logic                unused_wdata;
`ifdef IO_IRQ_EN
  logic [NUM_BTN-1:0]  mask;
`endif

  assign unused_wdata = ^wdata[IO_DATA_W-1:NUM_BTN];

  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk   (clk_hw),
        .rst   (rst),
        .button(Button[i]),
        .level (btn_level[i]),
        .rise  (btn_rise[i]),
        .pulse (btn_pulse[i])
      );
    end
  endgenerate

  assign evt_clr = (wr_en && addr == IO_ADDR_EVT) ? wdata[NUM_BTN-1:0] : '0;

  always_ff @(posedge clk_hw) begin
    if (rst) begin
      sw_sync1 <= '0;
      sw_sync2 <= '0;
      evt      <= '0;
      rdata    <= '0;
    end else begin
      sw_sync1 <= Switches;
      sw_sync2 <= sw_sync1;
      // Set is applied after clear so a coinciding pulse keeps the flag.
      evt      <= (evt & ~evt_clr) | btn_rise;
      if (rd_en) begin
        case (addr)
          IO_ADDR_SW:  rdata <= IO_DATA_W'(sw_sync2);
          IO_ADDR_BTN: rdata <= IO_DATA_W'(btn_level);
          IO_ADDR_EVT: rdata <= IO_DATA_W'(evt);
          default: begin
`ifdef IO_IRQ_EN
            rdata <= IO_DATA_W'(mask);
`else
            rdata <= '0;
`endif
          end
        endcase
      end
    end
  end

`ifdef IO_IRQ_EN
  always_ff @(posedge clk_hw) begin
    if (rst) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_en && addr == IO_ADDR_MASK) begin
        mask <= wdata[NUM_BTN-1:0];
      end
      irq <= |(evt & mask);
    end
  end
`endif

endmodule

// File: tb/tb_io_input_unit.sv
// tb/tb_io_input_unit.sv - directed and randomized self-checking bench for io_input_unit
// Build with IO_IRQ_EN defined to also exercise the mask register and irq output.
module tb_io_input_unit;

  localparam int NUM_BTN   = 2;
  localparam int SW_WIDTH  = 8;
  localparam int DB_CYCLES = 4;
  localparam bit [7:0] DB_MASK = 8'((1 << DB_CYCLES) - 1);

  logic        clk_hw = 1'b0;
  logic        rst;
  logic [7:0]  Switches;
  logic [1:0]  Button;
  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  btn_level;
  logic [1:0]  btn_pulse;
`ifdef IO_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  // Reference model state: values expected after the most recent clock edge.
  bit [1:0]  m_b1, m_b2, m_lvl, m_rose, m_pulse, m_evt, m_mask;
  bit [7:0]  m_sw1, m_sw2;
  bit [7:0]  m_hist [2];
  int        m_nvalid [2];
  bit        m_irq;
  bit [31:0] m_rdata;

  io_input_unit #(
    .NUM_BTN  (NUM_BTN),
    .SW_WIDTH (SW_WIDTH),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk_hw   (clk_hw),
    .rst      (rst),
    .Switches (Switches),
    .Button   (Button),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
`ifdef IO_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk_hw = ~clk_hw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Level flips once the last DB_CYCLES synchronized samples all disagree with it;
  // the pulse and event follow one edge after the rise.
  task automatic model_step();
    bit [1:0] lvl_n;
    bit [1:0] rose_n;
    bit [1:0] clr;
    bit [7:0] win;
    if (rst) begin
      m_b1 = '0; m_b2 = '0; m_lvl = '0; m_rose = '0; m_pulse = '0;
      m_evt = '0; m_mask = '0; m_sw1 = '0; m_sw2 = '0;
      m_irq = 1'b0; m_rdata = '0;
      for (int i = 0; i < 2; i++) begin
        m_hist[i]   = '0;
        m_nvalid[i] = 0;
      end
    end else begin
      lvl_n  = m_lvl;
      rose_n = '0;
      for (int i = 0; i < 2; i++) begin
        m_hist[i] = {m_hist[i][6:0], m_b2[i]};
        if (m_nvalid[i] < 8) m_nvalid[i]++;
        win = m_hist[i] & DB_MASK;
        if (m_nvalid[i] >= DB_CYCLES && win == (m_lvl[i] ? 8'h00 : DB_MASK)) begin
          lvl_n[i]  = ~m_lvl[i];
          rose_n[i] = ~m_lvl[i];
        end
      end
      clr = (wr_en && addr == 2'd2) ? wdata[1:0] : 2'b00;
      if (rd_en) begin
        case (addr)
          2'd0: m_rdata = {24'h0, m_sw2};
          2'd1: m_rdata = {30'h0, m_lvl};
          2'd2: m_rdata = {30'h0, m_evt};
          default: begin
`ifdef IO_IRQ_EN
            m_rdata = {30'h0, m_mask};
`else
            m_rdata = 32'h0;
`endif
          end
        endcase
      end
`ifdef IO_IRQ_EN
      m_irq = |(m_evt & m_mask);
      if (wr_en && addr == 2'd3) m_mask = wdata[1:0];
`endif
      m_evt   = (m_evt & ~clr) | m_rose;
      m_pulse = m_rose;
      m_rose  = rose_n;
      m_lvl   = lvl_n;
      m_b2    = m_b1;
      m_b1    = Button;
      m_sw2   = m_sw1;
      m_sw1   = Switches;
    end
  endtask

  task automatic check_model();
    check("model_rdata", rdata, m_rdata);
    check("model_level", 32'(btn_level), 32'(m_lvl));
    check("model_pulse", 32'(btn_pulse), 32'(m_pulse));
`ifdef IO_IRQ_EN
    check("model_irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic tick();
    @(posedge clk_hw);
    model_step();
    @(negedge clk_hw);
    check_model();
  endtask

  task automatic do_read(input logic [1:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst = 1'b1; Switches = '0; Button = '0; addr = '0;
    rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    tick();
    tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_pulse", 32'(btn_pulse), 32'h0);
`ifdef IO_IRQ_EN
    check("rst_irq", 32'(irq), 32'h0);
`endif
    rst = 1'b0;
    repeat (3) tick();

    // Three-cycle glitch must be rejected.
    Button = 2'b01;
    repeat (3) tick();
    Button = 2'b00;
    for (int e = 0; e < 8; e++) begin
      tick();
      check("glitch_level", 32'(btn_level), 32'h0);
      check("glitch_pulse", 32'(btn_pulse), 32'h0);
    end
    do_read(2'd2);
    check("glitch_evt", rdata, 32'h0);

    // Steady press: first sampled at edge k (e = 0).
    Button = 2'b01;
    tick();
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("press_level", 32'(btn_level[0]), 32'(e >= 5));
      check("press_pulse", 32'(btn_pulse[0]), 32'(e == 6));
    end
    do_read(2'd2);
    check("press_evt", rdata, 32'h1);

    Switches = 8'h02;
    repeat (3) tick();
    do_read(2'd0);
    check("sw_read", rdata, 32'h2);

    Button = 2'b11;
    repeat (8) tick();
    do_read(2'd2);
    check("evt_both", rdata, 32'h3);
    do_write(2'd2, 32'h1);
    do_read(2'd2);
    check("w1c_bit0", rdata, 32'h2);

    // Clear of evt[1] coinciding with a fresh Button[1] rise.
    Button = 2'b01;
    repeat (8) tick();
    check("release_level", 32'(btn_level), 32'h1);
    Button = 2'b11;
    tick();
    repeat (5) tick();
    addr = 2'd2; wdata = 32'h2; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; wdata = '0;
    check("coincide_pulse", 32'(btn_pulse[1]), 32'h1);
    do_read(2'd2);
    check("set_wins", rdata, 32'h2);

    // Mask / irq sequence.
    do_write(2'd2, 32'h3);
    do_write(2'd3, 32'h2);
    Button = 2'b00;
    repeat (8) tick();
    Button = 2'b01;
    repeat (8) tick();
    do_read(2'd2);
    check("evt_01", rdata, 32'h1);
    do_read(2'd3);
`ifdef IO_IRQ_EN
    check("mask_read", rdata, 32'h2);
    check("irq_masked", 32'(irq), 32'h0);
`else
    check("mask_absent", rdata, 32'h0);
`endif
    Button = 2'b11;
    tick();
    for (int e = 1; e <= 8; e++) begin
      tick();
`ifdef IO_IRQ_EN
      check("irq_rise", 32'(irq), 32'(e >= 7));
`else
      check("evt1_pulse", 32'(btn_pulse[1]), 32'(e == 6));
`endif
    end
    do_write(2'd2, 32'h2);
`ifdef IO_IRQ_EN
    check("irq_hold", 32'(irq), 32'h1);
`endif
    tick();
`ifdef IO_IRQ_EN
    check("irq_clear", 32'(irq), 32'h0);
`endif

    // Reset in the middle of a debounce with the button held.
    Button = 2'b00;
    repeat (8) tick();
    Button = 2'b01;
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_level", 32'(btn_level), 32'h0);
    check("midrst_pulse", 32'(btn_pulse), 32'h0);
    tick();
    check("midrst_pulse2", 32'(btn_pulse), 32'h0);
    rst = 1'b0;
    pulses = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("release_level0", 32'(btn_level[0]), 32'(e >= 5));
      check("release_pulse0", 32'(btn_pulse[0]), 32'(e == 6));
      pulses += int'(btn_pulse[0]);
    end
    check("release_one_pulse", 32'(pulses), 32'h1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) Button = Button ^ 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) Switches = 8'($urandom);
      rd_en = 1'($urandom_range(0, 1));
      wr_en = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom);
      wdata = $urandom;
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_unit.md
IO_INPUT_UNIT -- requirements
Module: io_input_unit

Interface
REQ-001 Parameter NUM_BTN, default 1: number of push-button inputs, legal range 1..8.
REQ-002 Parameter SW_WIDTH, default 8: number of switch inputs, legal range 1..16.
REQ-003 Parameter DB_CYCLES, default 4: consecutive stable cycles required to accept a button change; must be at least 1.
REQ-004 clk_hw  in  1: single clock; all state changes on its rising edge.
REQ-005 rst  in  1: synchronous, active-high reset.
REQ-006 Switches  in  SW_WIDTH: asynchronous board switches.
REQ-007 Button  in  NUM_BTN: asynchronous, bouncing push-buttons.
REQ-008 addr  in  2: CPU register select.
REQ-009 rd_en  in  1: CPU read strobe.
REQ-010 wr_en  in  1: CPU write strobe.
REQ-011 wdata  in  32: CPU write data.
REQ-012 rdata  out  32: registered CPU read data.
REQ-013 btn_level  out  NUM_BTN: debounced button level.
REQ-014 btn_pulse  out  NUM_BTN: one-cycle pulse on each debounced rising edge.
REQ-015 irq  out  1: level interrupt; present only with IO_IRQ_EN.

Function
REQ-016 Switches and Button shall each pass through a 2-flop synchronizer before any other use.
REQ-017 Each button shall have a debounce counter of width clog2(DB_CYCLES+1).
- Synced value equal to btn_level: counter clears.
- Synced value differs: counter increments.
- Counter equal to DB_CYCLES-1 and synced value still differs: btn_level takes the synced value and the counter clears.
REQ-018 Pin-to-btn_level latency shall be exactly 2+DB_CYCLES clock edges; any glitch shorter than DB_CYCLES synced cycles shall produce no change.
REQ-019 btn_pulse[i] shall be high for exactly one cycle, on the edge after btn_level[i] rises; a falling edge shall produce no pulse.
REQ-020 Event flag evt[i] shall set on the same edge btn_pulse[i] asserts and shall remain set until cleared.
REQ-021 A write with addr=2 shall clear every evt[i] whose wdata[i]=1 (write-1-to-clear).
REQ-022 If a set and a clear of the same flag coincide, set shall win.
REQ-023 Register map, all values zero-extended to 32 bits:
- addr 0: synced Switches.
- addr 1: btn_level.
- addr 2: evt.
- addr 3: irq mask with IO_IRQ_EN, otherwise reads 0.
REQ-024 rdata shall update on the edge where rd_en=1 (one-cycle read latency) and shall hold its value otherwise.
REQ-025 A read shall have no side effects.
REQ-026 Writes to addr 0 and addr 1 shall be ignored.
REQ-027 Writes to addr 3 shall be ignored without IO_IRQ_EN.
REQ-028 If rd_en and wr_en are both asserted, both shall take effect; a read of addr 2 shall return the pre-clear value.

Reset
REQ-029 While rst=1 the following shall be 0: synchronizers, debounce counters, btn_level, btn_pulse, evt, rdata, mask and irq.
REQ-030 A reset asserted mid-debounce shall discard the partial count, and no pulse shall be generated on reset release.
REQ-031 A button held high through reset release shall produce btn_level=1 exactly 2+DB_CYCLES edges after release, followed by one pulse.

Configuration
REQ-032 Feature macro: IO_IRQ_EN.
REQ-033 With IO_IRQ_EN defined:
- addr 3 holds a NUM_BTN-bit mask, written by wr_en with addr=3.
- irq is registered and equals the OR of (evt AND mask), one edge after evt or mask changes.
REQ-034 Without IO_IRQ_EN: the irq port, the mask register and the mask logic shall not exist, and addr 3 reads 0.

Structure
REQ-035 A shared package io_pkg shall hold:
- register address constants IO_ADDR_SW=0, IO_ADDR_BTN=1, IO_ADDR_EVT=2, IO_ADDR_MASK=3;
- the 32-bit data width constant.
REQ-036 Per-button synchronizer plus debounce plus edge detection shall be a sub-module, btn_debounce, instantiated NUM_BTN times via generate.

Verification
REQ-037 Bench parameters: NUM_BTN=2, DB_CYCLES=4, SW_WIDTH=8. Clock period 10 ns, rst=1 for 2 cycles.
REQ-038 Button[0] high for 3 cycles then low -> btn_level, btn_pulse and evt stay 0.
REQ-039 Button[0] steady high, first sampled at edge k:
- btn_level[0]=1 after edge k+5;
- btn_pulse[0]=1 for exactly the cycle after edge k+6;
- evt=2'b01.
REQ-040 Switches=8'h02, wait 3 cycles, rd_en with addr=0 -> rdata=32'h00000002 one edge later.
REQ-041 With evt=2'b11: write addr 2 wdata=1 -> evt=2'b10. A write of 1 to bit 1 coinciding with a new Button[1] pulse -> evt[1] stays 1.
REQ-042 IO_IRQ_EN: mask=2'b10 and evt=2'b01 -> irq=0. Button[1] event -> irq=1 one edge after evt[1] sets. Clear evt[1] -> irq=0 one edge later.
REQ-043 rst asserted at count 2 of a debounce, Button held -> no pulse during reset; btn_level rises 6 edges after release, with exactly one pulse.
